capture_sdram_writer: RTL and testbench

Parametrised capture-to-SDRAM streaming writer that drives the HPS f2h_sdram0 Avalon-MM write port. It packs narrow logic-analyzer samples into DATA_W-wide words and buffers them in an internal FIFO. It then issues fixed-length Avalon bursts into a ring buffer in SDRAM. Successor to the fixed 256-bit direct port: generalised in data, sample and burst width, with flush, wrap and overflow handling.

---
 rtl/capture_sdram_writer_if.sv | 40 ++++
 rtl/capture_sdram_writer.sv | 188 ++++++++++++++++++
 tb/tb_capture_sdram_writer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/capture_sdram_writer_if.sv
// Signal bundle between a capture source/control block and capture_sdram_writer.
// Latency: none (wires only).
// Backpressure: avm_waitrequest from the Avalon slave stalls the writer; samples have no backpressure.
// Ports: control (start/stop/base_addr/buf_words), sample stream, Avalon-MM write master, status.
// master modport = writer side, slave modport = the surrounding system (control, capture, SDRAM port).
interface capture_sdram_writer_if #(
    parameter int DATA_W   = 256,
    parameter int SAMPLE_W = 32,
    parameter int ADDR_W   = 27,
    parameter int BURST_W  = 8
);
    logic                  start;
    logic                  stop;
    logic [ADDR_W-1:0]     base_addr;
    logic [ADDR_W-1:0]     buf_words;
    logic                  sample_valid;
    logic [SAMPLE_W-1:0]   sample_data;
    logic [ADDR_W-1:0]     avm_address;
    logic [BURST_W-1:0]    avm_burstcount;
    logic                  avm_write;
    logic [DATA_W-1:0]     avm_writedata;
    logic [DATA_W/8-1:0]   avm_byteenable;
    logic                  avm_waitrequest;
    logic                  busy;
    logic                  overflow;
    logic                  wrapped;
    logic [ADDR_W-1:0]     wr_offset;

    modport master (
        input  start, stop, base_addr, buf_words, sample_valid, sample_data, avm_waitrequest,
        output avm_address, avm_burstcount, avm_write, avm_writedata, avm_byteenable,
               busy, overflow, wrapped, wr_offset
    );

    modport slave (
        output start, stop, base_addr, buf_words, sample_valid, sample_data, avm_waitrequest,
        input  avm_address, avm_burstcount, avm_write, avm_writedata, avm_byteenable,
               busy, overflow, wrapped, wr_offset
    );
endinterface

// File: rtl/capture_sdram_writer.sv
// Packs capture samples into DATA_W words, queues them, and writes fixed-length Avalon bursts into an SDRAM ring.
// Latency: word enters FIFO 1 cycle after its last sample; FIFO to avm_write at least 1 cycle.
// Backpressure: avm_waitrequest stalls beats (FIFO absorbs); a completed word arriving at a full FIFO is dropped and flags overflow.
// Ports: clk_clk, reset_reset_n (async, active low), bus (capture_sdram_writer_if.master).
// Optional: define CAPTURE_SDRAM_WRITER_ONESHOT_EN to stop at the ring end (auto flush, no wrap) instead of wrapping.
module capture_sdram_writer #(
    parameter int DATA_W     = 256,
    parameter int SAMPLE_W   = 32,
    parameter int ADDR_W     = 27,
    parameter int BURST_W    = 8,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    capture_sdram_writer_if.master bus
);
    localparam int SPW = DATA_W / SAMPLE_W;
    localparam int PW  = (SPW > 1) ? $clog2(SPW) : 1;
    localparam int FAW = $clog2(FIFO_DEPTH);
    localparam int CW  = FAW + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, bufw_q, off_q, addr_q;
    logic                flushing_q, ovf_q, wrap_q;
    logic [DATA_W-1:0]   pk_dat_q;
    logic [PW-1:0]       pk_cnt_q;
    logic [CW-1:0]       wptr_q, rptr_q;
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [BURST_W-1:0]  bcnt_q, beat_q;

    logic [CW-1:0]       fifo_cnt;
    logic                fifo_full;
    logic [ADDR_W-1:0]   room, n_full, cnt_a, n_go, off_adv;
    logic                accept, word_done, flush_push, push_req, push, drop;
    logic [DATA_W-1:0]   pk_word, push_dat;
    logic                avm_write_w, beat_acc, last_beat, ring_end, start_ok, burst_load;

    assign fifo_cnt  = wptr_q - rptr_q;
    assign fifo_full = (fifo_cnt == CW'(FIFO_DEPTH));
    assign cnt_a     = ADDR_W'(fifo_cnt);
    // Space left before the ring end; a burst may never cross it.
    assign room      = bufw_q - off_q;
    assign n_full    = (room < ADDR_W'(BURST_LEN)) ? room : ADDR_W'(BURST_LEN);
    // While flushing a short burst uses whatever is queued; otherwise cnt_a >= n_full when a burst launches.
    assign n_go      = (cnt_a < n_full) ? cnt_a : n_full;
    assign off_adv   = off_q + ADDR_W'(bcnt_q);
    assign ring_end  = (off_adv == bufw_q);

    assign start_ok    = (state_q == S_IDLE) && bus.start && !bus.stop;
    assign avm_write_w = (state_q == S_BURST);
    assign beat_acc    = avm_write_w && !bus.avm_waitrequest;
    assign last_beat   = beat_acc && (beat_q == bcnt_q - 1'b1);

    // The stop cycle itself accepts no sample, so the flushed tail is exactly what preceded stop.
    assign accept     = (state_q != S_IDLE) && !flushing_q && !bus.stop && bus.sample_valid;
    assign word_done  = accept && (pk_cnt_q == PW'(SPW - 1));
    assign flush_push = flushing_q && (pk_cnt_q != '0);
    assign push_req   = word_done || flush_push;
    assign push_dat   = word_done ? pk_word : pk_dat_q;
    assign push       = push_req && !fifo_full;
    assign drop       = push_req && fifo_full;

    always_comb begin
        pk_word = pk_dat_q;
        for (int k = 0; k < SPW; k++) begin
            if (pk_cnt_q == PW'(k)) begin
                pk_word[k*SAMPLE_W +: SAMPLE_W] = bus.sample_data;
            end
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        burst_load = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_ok) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (flushing_q && (pk_cnt_q == '0) && (fifo_cnt == '0)) begin
                    state_d = S_IDLE;
                end else if (room == '0) begin
                    // Only reachable in one-shot mode: the ring is full and queued data has nowhere to go.
                    state_d = S_IDLE;
                end else if ((cnt_a >= n_full) || (flushing_q && (fifo_cnt != '0))) begin
                    state_d    = S_BURST;
                    burst_load = 1'b1;
                end
            end
            S_BURST: begin
                if (last_beat) state_d = S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (push) mem[wptr_q[FAW-1:0]] <= push_dat;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            base_q     <= '0;
            bufw_q     <= '0;
            off_q      <= '0;
            addr_q     <= '0;
            flushing_q <= 1'b0;
            ovf_q      <= 1'b0;
            wrap_q     <= 1'b0;
            pk_dat_q   <= '0;
            pk_cnt_q   <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            bcnt_q     <= '0;
            beat_q     <= '0;
        end else if (start_ok) begin
            base_q     <= bus.base_addr;
            bufw_q     <= (bus.buf_words == '0) ? ADDR_W'(1) : bus.buf_words;
            off_q      <= '0;
            flushing_q <= 1'b0;
            ovf_q      <= 1'b0;
            wrap_q     <= 1'b0;
            pk_dat_q   <= '0;
            pk_cnt_q   <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
        end else begin
            if (bus.stop && (state_q != S_IDLE)) flushing_q <= 1'b1;

            if (word_done || flush_push) begin
                pk_dat_q <= '0;
                pk_cnt_q <= '0;
            end else if (accept) begin
                pk_dat_q <= pk_word;
                pk_cnt_q <= pk_cnt_q + 1'b1;
            end

            if (push) wptr_q <= wptr_q + 1'b1;
            if (drop) ovf_q  <= 1'b1;

            if (burst_load) begin
                addr_q <= base_q + off_q;
                bcnt_q <= BURST_W'(n_go);
                beat_q <= '0;
            end

            if (beat_acc) begin
                rptr_q <= rptr_q + 1'b1;
                beat_q <= beat_q + 1'b1;
            end

            if (last_beat) begin
                if (ring_end) begin
`ifdef CAPTURE_SDRAM_WRITER_ONESHOT_EN
                    off_q      <= off_adv;
                    flushing_q <= 1'b1;
`else
                    off_q  <= '0;
                    wrap_q <= 1'b1;
`endif
                end else begin
                    off_q <= off_adv;
                end
            end
        end
    end

    assign bus.avm_write      = avm_write_w;
    assign bus.avm_address    = addr_q;
    assign bus.avm_burstcount = bcnt_q;
    assign bus.avm_writedata  = avm_write_w ? mem[rptr_q[FAW-1:0]] : '0;
    assign bus.avm_byteenable = '1;
    assign bus.busy           = (state_q != S_IDLE);
    assign bus.overflow       = ovf_q;
    assign bus.wrapped        = wrap_q;
    assign bus.wr_offset      = off_q;
endmodule

// File: tb/tb_capture_sdram_writer.sv
module tb_capture_sdram_writer;
    localparam int DATA_W   = 256;
    localparam int SAMPLE_W = 32;
    localparam int ADDR_W   = 27;
    localparam int BURST_W  = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    capture_sdram_writer_if #(.DATA_W(DATA_W), .SAMPLE_W(SAMPLE_W), .ADDR_W(ADDR_W), .BURST_W(BURST_W)) bus ();

    capture_sdram_writer dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus           (bus)
    );

    int checks   = 0;
    int failures = 0;
    int wmode    = 0;   // 0: no waitrequest, 1: random 50%, 2: held high

    // Bus monitor: records every burst header and every accepted beat, and flags
    // any change of address/burstcount while a burst is in progress.
    logic [DATA_W-1:0]  beats_q[$];
    logic [ADDR_W-1:0]  baddr_q[$];
    int                 bcnt_q[$];
    int                 hold_err = 0;
    logic               in_b = 1'b0;
    logic [ADDR_W-1:0]  cur_a = '0;
    logic [BURST_W-1:0] cur_c = '0;
    int                 bidx = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_b = 1'b0;
            bidx = 0;
        end else if (bus.avm_write) begin
            if (!in_b) begin
                in_b  = 1'b1;
                cur_a = bus.avm_address;
                cur_c = bus.avm_burstcount;
                baddr_q.push_back(cur_a);
                bcnt_q.push_back(int'(cur_c));
            end else if (bus.avm_address != cur_a || bus.avm_burstcount != cur_c) begin
                hold_err++;
            end
            if (!bus.avm_waitrequest) begin
                beats_q.push_back(bus.avm_writedata);
                bidx++;
                if (bidx == int'(cur_c)) begin
                    in_b = 1'b0;
                    bidx = 0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mkword(input int first, input int n);
        logic [DATA_W-1:0] w;
        w = '0;
        for (int j = 0; j < n; j++) w[j*SAMPLE_W +: SAMPLE_W] = 32'(first + j);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        case (wmode)
            0:       bus.avm_waitrequest = 1'b0;
            1:       bus.avm_waitrequest = 1'($urandom_range(0, 1));
            default: bus.avm_waitrequest = 1'b1;
        endcase
    endtask

    task automatic feed(input int n, input int first);
        for (int i = 0; i < n; i++) begin
            tick();
            bus.sample_valid = 1'b1;
            bus.sample_data  = 32'(first + i);
        end
        tick();
        bus.sample_valid = 1'b0;
    endtask

    // Returns once n beats have been accepted (or the budget expires).
    task automatic wait_beats(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (beats_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, beats_q.size(), n);
    endtask

    task automatic clear_mon();
        beats_q.delete();
        baddr_q.delete();
        bcnt_q.delete();
        hold_err = 0;
    endtask

    task automatic do_start(input int base, input int words);
        tick();
        bus.base_addr = ADDR_W'(base);
        bus.buf_words = ADDR_W'(words);
        bus.start     = 1'b1;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic pulse_stop();
        tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (bus.busy && k < 300) begin
            tick();
            k++;
        end
        check(tag, bus.busy, 0);
    endtask

    task automatic check_words(input string tag, input int nwords, input int first);
        int errs;
        errs = 0;
        for (int i = 0; i < nwords; i++) begin
            if (beats_q.size() <= i || beats_q[i] !== mkword(first + 8 * i, 8)) errs++;
        end
        check(tag, errs, 0);
    endtask

    initial begin
        int cnt4 [4];
        int adr4 [4];

        bus.start = 1'b0;
        bus.stop = 1'b0;
        bus.base_addr = '0;
        bus.buf_words = '0;
        bus.sample_valid = 1'b0;
        bus.sample_data = '0;
        bus.avm_waitrequest = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_write", bus.avm_write, 0);
        check("rst_be", bus.avm_byteenable, 32'hFFFF_FFFF);
        check("rst_addr", bus.avm_address, 0);
        check("rst_bcnt", bus.avm_burstcount, 0);
        check("rst_data", bus.avm_writedata, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_wrap", bus.wrapped, 0);
        check("rst_off", bus.wr_offset, 0);
        rst_n = 1'b1;

        // 1: 128 samples, one full burst
        clear_mon();
        wmode = 0;
        do_start('h100, 64);
        check("t1_busy_start", bus.busy, 1);
        feed(128, 0);
        wait_beats(16, 100, "t1_beats");
        check("t1_addr", baddr_q[0], 'h100);
        check("t1_bcnt", bcnt_q[0], 16);
        check("t1_beat0", beats_q[0], mkword(0, 8));
        check_words("t1_data", 16, 0);
        check("t1_off", bus.wr_offset, 16);
        check("t1_busy", bus.busy, 1);
        pulse_stop();
        wait_idle("t1_idle");

        // 2: random waitrequest, 512 samples
        clear_mon();
        wmode = 1;
        do_start('h100, 64);
        feed(512, 0);
        wait_beats(64, 2000, "t2_beats");
        check("t2_nburst", baddr_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t2_addr%0d", k), baddr_q[k], 'h100 + 16 * k);
            check($sformatf("t2_bcnt%0d", k), bcnt_q[k], 16);
        end
        check_words("t2_data", 64, 0);
        check("t2_hold", hold_err, 0);
        check("t2_ovf", bus.overflow, 0);
        check("t2_wrap", bus.wrapped, 1);
        wmode = 0;
        pulse_stop();
        wait_idle("t2_idle");

        // 3: 20-word ring, bursts never cross the ring end
        clear_mon();
        do_start('h100, 20);
        feed(288, 0);
        wait_beats(36, 200, "t3_beats36");
        check("t3_off16", bus.wr_offset, 16);
        check("t3_wrap", bus.wrapped, 1);
        feed(32, 288);
        wait_beats(40, 200, "t3_beats40");
        adr4 = '{'h100, 'h110, 'h100, 'h110};
        cnt4 = '{16, 4, 16, 4};
        check("t3_nburst", baddr_q.size(), 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t3_addr%0d", k), baddr_q[k], adr4[k]);
            check($sformatf("t3_bcnt%0d", k), bcnt_q[k], cnt4[k]);
        end
        check_words("t3_data", 40, 0);
        check("t3_off0", bus.wr_offset, 0);
        pulse_stop();
        wait_idle("t3_idle");

        // 4: 13 samples then stop -> two single-beat bursts, second zero-padded
        clear_mon();
        do_start('h100, 64);
        feed(13, 0);
        pulse_stop();
        check("t4_busy_flush", bus.busy, 1);
        wait_beats(2, 50, "t4_beats");
        repeat (3) tick();
        check("t4_busy_end", bus.busy, 0);
        check("t4_nburst", baddr_q.size(), 2);
        check("t4_addr0", baddr_q[0], 'h100);
        check("t4_addr1", baddr_q[1], 'h101);
        check("t4_bcnt0", bcnt_q[0], 1);
        check("t4_bcnt1", bcnt_q[1], 1);
        check("t4_w0", beats_q[0], mkword(0, 8));
        check("t4_w1", beats_q[1], mkword(8, 5));
        check("t4_off", bus.wr_offset, 2);

        // 5: waitrequest held high -> FIFO fills, later words dropped
        clear_mon();
        do_start('h100, 64);
        wmode = 2;
        feed(600, 0);
        check("t5_ovf", bus.overflow, 1);
        repeat (1400) tick();
        check("t5_nobeats", beats_q.size(), 0);
        pulse_stop();
        wmode = 0;
        wait_beats(64, 500, "t5_beats");
        check_words("t5_data", 64, 0);
        check("t5_hold", hold_err, 0);
        check("t5_nburst", baddr_q.size(), 4);
        wait_idle("t5_idle");
        check("t5_ovf_kept", bus.overflow, 1);
        do_start('h300, 64);
        check("t5_ovf_clr", bus.overflow, 0);
        check("t5_wrap_clr", bus.wrapped, 0);

        // 6: reset in the middle of a 16-beat burst
        clear_mon();
        feed(128, 1000);
        wait_beats(5, 100, "t6_beats5");
        check("t6_write_pre", bus.avm_write, 1);
        rst_n = 1'b0;
        #1;
        check("t6_write", bus.avm_write, 0);
        check("t6_busy", bus.busy, 0);
        check("t6_off", bus.wr_offset, 0);
        repeat (2) tick();
        check("t6_nobeats", beats_q.size(), 5);
        rst_n = 1'b1;
        clear_mon();
        do_start('h200, 64);
        feed(128, 5000);
        wait_beats(16, 100, "t6_beats_new");
        check("t6_addr", baddr_q[0], 'h200);
        check("t6_bcnt", bcnt_q[0], 16);
        check_words("t6_data", 16, 5000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
